dmem_responder: RTL and testbench
=================================

DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 Parameter DEPTH, default 2048: number of 32-bit words in the data array.
REQ-002 Parameter TOHOST_ADDR, default 32'h0000_1000: byte address of the test-status mailbox register.
REQ-003 Clk  input  1  sole clock; all state updates on rising edge.
REQ-004 Reset_n  input  1  synchronous, active-low reset.
REQ-005 DMEM_addr  input  32  byte address from core.
REQ-006 DMEM_wr_data  input  32  store data from core.
REQ-007 DMEM_wr_en  input  1  store strobe, one word per asserted cycle.
REQ-008 DMEM_rst  input  1  core-side flush; clears read data, blocks store.
REQ-009 DMEM_rd_data  output  32  registered load data.
REQ-010 Test_done  output  1  high once a status word has been written to TOHOST_ADDR.
REQ-011 Test_pass  output  1  valid while Test_done is high; 1 = pass.
REQ-012 Test_num  output  31  failing test number (status word bits [31:1]); 0 on pass.
REQ-013 Cycle_count  output  32  cycles spent in RUN.
REQ-014 Addr_err  output  1  sticky flag for misaligned or out-of-range access.

Function
REQ-015 Word index SHALL be DMEM_addr[31:2]; an access is in range when the index < DEPTH.
REQ-016 Read latency SHALL be 1 cycle: DMEM_rd_data at edge N+1 reflects the DMEM_addr presented in cycle N.
REQ-017 In-range read SHALL return mem[index]; read of TOHOST_ADDR SHALL return the mailbox register; any other address SHALL return 0.
REQ-018 In-range write with DMEM_wr_en=1, DMEM_rst=0, Reset_n=1 SHALL update mem[index] at the clock edge.
REQ-019 Same-cycle read and write to the same word SHALL be read-first: DMEM_rd_data returns the old value.
REQ-020 DMEM_rst=1 SHALL load DMEM_rd_data with 0 and suppress any write in that cycle.
REQ-021 A write to TOHOST_ADDR SHALL update the mailbox register only, never the array, even when TOHOST_ADDR falls inside the array range.
REQ-022 An access with DMEM_addr[1:0]!=0, or out of range and not TOHOST_ADDR, SHALL set Addr_err. A write SHALL set it when DMEM_wr_en=1; a read SHALL set it only while the FSM is in RUN. Such writes are dropped and such reads return 0.
REQ-023 The FSM SHALL have states RUN, PASS and FAIL, and SHALL enter RUN on reset.
REQ-024 RUN->PASS SHALL occur on a mailbox write of exactly 32'h1; RUN->FAIL SHALL occur on a mailbox write with bit0=1 and bits[31:1]!=0; a mailbox write with bit0=0 SHALL leave the FSM in RUN.
REQ-025 PASS and FAIL SHALL be terminal until Reset_n=0; later mailbox writes SHALL not change the FSM state, Test_pass or Test_num.
REQ-026 Test_done SHALL be 1 exactly when the state is PASS or FAIL, asserted the cycle after the mailbox write.
REQ-027 Test_pass=1 only in PASS; in FAIL, Test_num SHALL hold the written bits[31:1].
REQ-028 Cycle_count SHALL increment by 1 each cycle in RUN, freeze in PASS/FAIL, and saturate at 32'hFFFF_FFFF without wrapping.

Reset
REQ-029 Reset_n=0 at a clock edge SHALL set DMEM_rd_data=0, mailbox=0, state=RUN, Test_done=0, Test_pass=0, Test_num=0, Cycle_count=0 and Addr_err=0.
REQ-030 Reset SHALL block writes in that cycle and SHALL leave array contents unchanged.
REQ-031 Reset asserted mid-test, including in PASS/FAIL, SHALL restart status tracking without corrupting memory.

Verification
REQ-032 Write 32'hDEAD_BEEF at addr 0x10, then read 0x10 -> rd_data=32'hDEAD_BEEF one cycle after the read address; Addr_err=0.
REQ-033 Same cycle: wr_en=1, addr 0x20, data 32'h5, with old contents 32'h3 -> rd_data=32'h3 next cycle; a following read of 0x20 returns 32'h5.
REQ-034 Write 32'h1 to TOHOST_ADDR after 50 RUN cycles -> Test_done=1, Test_pass=1, Test_num=0, Cycle_count frozen at 51. A later write of 32'h7 leaves all outputs unchanged.
REQ-035 Write 32'h7 to TOHOST_ADDR -> state FAIL, Test_pass=0, Test_num=3. A separate write of 32'h6 from RUN leaves Test_done=0.
REQ-036 Write to addr 0x2 -> Addr_err=1 and no array change. Write to word index DEPTH -> dropped; a read there returns 0.
REQ-037 DMEM_rst=1 with wr_en=1 at 0x40 -> rd_data=0 and mem[0x40] unchanged. Reset_n=0 in FAIL -> all status outputs 0 and prior memory data still readable.

Source files
------------

// File: rtl/dmem_responder_if.sv
// Data-memory port between a core and the memory responder.
//   DMEM_addr     core -> mem  byte address
//   DMEM_wr_data  core -> mem  store data
//   DMEM_wr_en    core -> mem  store strobe (one word per cycle)
//   DMEM_rst      core -> mem  flush: clears read data, blocks the store
//   DMEM_rd_data  mem -> core  registered load data
// master: core side, slave: memory side.
interface dmem_responder_if;
  logic [31:0] DMEM_addr;
  logic [31:0] DMEM_wr_data;
  logic        DMEM_wr_en;
  logic        DMEM_rst;
  logic [31:0] DMEM_rd_data;

  modport master (
    output DMEM_addr,
    output DMEM_wr_data,
    output DMEM_wr_en,
    output DMEM_rst,
    input  DMEM_rd_data
  );

  modport slave (
    input  DMEM_addr,
    input  DMEM_wr_data,
    input  DMEM_wr_en,
    input  DMEM_rst,
    output DMEM_rd_data
  );
endinterface

// File: rtl/dmem_responder.sv
// Data-memory responder for core test runs.
// Word array with one-cycle registered reads (read-first on same-word write),
// plus a "tohost" mailbox register that records the test status word and
// drives a small RUN/PASS/FAIL tracker.
//
// Ports:
//   Clk          sole clock, rising edge
//   Reset_n      synchronous active-low reset (array contents are kept)
//   dmem         slave side of the data-memory port
//   Test_done    state is PASS or FAIL
//   Test_pass    state is PASS
//   Test_num     failing test number (status bits [31:1]) while in FAIL, else 0
//   Cycle_count  cycles spent in RUN, saturating
//   Addr_err     sticky misaligned / out-of-range access flag
module dmem_responder #(
  parameter int unsigned DEPTH       = 2048,
  parameter logic [31:0] TOHOST_ADDR = 32'h0000_1000
) (
  input  logic                   Clk,
  input  logic                   Reset_n,
  dmem_responder_if.slave        dmem,
  output logic                   Test_done,
  output logic                   Test_pass,
  output logic [30:0]            Test_num,
  output logic [31:0]            Cycle_count,
  output logic                   Addr_err
);

  localparam int unsigned IdxW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {
    StRun,
    StPass,
    StFail
  } state_e;

  // Storage
  logic [31:0] mem_q [DEPTH];

  state_e      state_q, state_d;
  logic [31:0] rd_data_q, rd_data_d;
  logic [31:0] mailbox_q, mailbox_d;
  logic [30:0] fail_num_q, fail_num_d;
  logic [31:0] cycle_count_q, cycle_count_d;
  logic        addr_err_q, addr_err_d;

  // Address decode
  logic [29:0]     word_idx;
  logic [IdxW-1:0] mem_idx;
  logic            in_range;
  logic            is_tohost;
  logic            misaligned;
  logic            acc_bad;
  logic            arr_hit;
  logic            wr_ok;
  logic            mem_we;
  logic            mbox_we;

  always_comb begin
    word_idx   = dmem.DMEM_addr[31:2];
    mem_idx    = word_idx[IdxW-1:0];
    in_range   = {2'b00, word_idx} < DEPTH;
    is_tohost  = dmem.DMEM_addr == TOHOST_ADDR;
    misaligned = dmem.DMEM_addr[1:0] != 2'b00;
    // The mailbox address is legal even when it lies beyond the array.
    acc_bad    = misaligned | (~in_range & ~is_tohost);
    // The mailbox shadows its array word for both reads and writes.
    arr_hit    = in_range & ~misaligned & ~is_tohost;
    wr_ok      = dmem.DMEM_wr_en & ~dmem.DMEM_rst;
    mem_we     = wr_ok & arr_hit;
    mbox_we    = wr_ok & is_tohost & ~misaligned;
  end

  // Next-state logic
  always_comb begin
    state_d       = state_q;
    rd_data_d     = rd_data_q;
    mailbox_d     = mailbox_q;
    fail_num_d    = fail_num_q;
    cycle_count_d = cycle_count_q;
    addr_err_d    = addr_err_q;

    // Read path samples the old array/mailbox value, giving read-first order.
    if (dmem.DMEM_rst) begin
      rd_data_d = '0;
    end else if (is_tohost && !misaligned) begin
      rd_data_d = mailbox_q;
    end else if (arr_hit) begin
      rd_data_d = mem_q[mem_idx];
    end else begin
      rd_data_d = '0;
    end

    if (mbox_we) begin
      mailbox_d = dmem.DMEM_wr_data;
    end

    // Bad stores always flag; bad loads only count while the test is live.
    if (acc_bad && (dmem.DMEM_wr_en || state_q == StRun)) begin
      addr_err_d = 1'b1;
    end

    if (state_q == StRun && cycle_count_q != 32'hFFFF_FFFF) begin
      cycle_count_d = cycle_count_q + 32'd1;
    end

    unique case (state_q)
      StRun: begin
        // Status words with bit0 clear are progress reports, not verdicts.
        if (mbox_we && dmem.DMEM_wr_data[0]) begin
          if (dmem.DMEM_wr_data == 32'h0000_0001) begin
            state_d = StPass;
          end else begin
            state_d    = StFail;
            fail_num_d = dmem.DMEM_wr_data[31:1];
          end
        end
      end
      StPass:  state_d = StPass;
      StFail:  state_d = StFail;
      default: state_d = StRun;
    endcase
  end

  // Status and read-data registers
  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      state_q       <= StRun;
      rd_data_q     <= '0;
      mailbox_q     <= '0;
      fail_num_q    <= '0;
      cycle_count_q <= '0;
      addr_err_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      rd_data_q     <= rd_data_d;
      mailbox_q     <= mailbox_d;
      fail_num_q    <= fail_num_d;
      cycle_count_q <= cycle_count_d;
      addr_err_q    <= addr_err_d;
    end
  end

  // Array is never cleared by reset; reset only blocks the store.
  always_ff @(posedge Clk) begin
    if (Reset_n && mem_we) begin
      mem_q[mem_idx] <= dmem.DMEM_wr_data;
    end
  end

  // Outputs
  always_comb begin
    dmem.DMEM_rd_data = rd_data_q;
    Test_done         = state_q != StRun;
    Test_pass         = state_q == StPass;
    Test_num          = (state_q == StFail) ? fail_num_q : '0;
    Cycle_count       = cycle_count_q;
    Addr_err          = addr_err_q;
  end

endmodule

// File: tb/tb_dmem_responder.sv
module tb_dmem_responder;

  localparam int unsigned DEPTH  = 2048;
  localparam logic [31:0] TOHOST = 32'h0000_1000;

  logic        Clk = 1'b0;
  logic        Reset_n;
  logic        Test_done;
  logic        Test_pass;
  logic [30:0] Test_num;
  logic [31:0] Cycle_count;
  logic        Addr_err;

  dmem_responder_if bus ();

  dmem_responder #(
    .DEPTH       (DEPTH),
    .TOHOST_ADDR (TOHOST)
  ) dut (
    .Clk         (Clk),
    .Reset_n     (Reset_n),
    .dmem        (bus),
    .Test_done   (Test_done),
    .Test_pass   (Test_pass),
    .Test_num    (Test_num),
    .Cycle_count (Cycle_count),
    .Addr_err    (Addr_err)
  );

  always #5 Clk = ~Clk;

  int total = 0;
  int bad   = 0;

  // Behavioural reference state
  logic [31:0] m_mem [int];
  logic [31:0] m_rd;
  logic [31:0] m_mbox;
  logic        m_done;
  logic        m_pass;
  logic [30:0] m_num;
  logic [31:0] m_cnt;
  logic        m_err;

  task automatic drive(input logic [31:0] a, input logic [31:0] d, input logic we,
                       input logic rs);
    bus.DMEM_addr    = a;
    bus.DMEM_wr_data = d;
    bus.DMEM_wr_en   = we;
    bus.DMEM_rst     = rs;
  endtask

  // Apply the rules of one clock edge to the reference state.
  task automatic model_edge();
    logic [31:0] a;
    logic [31:0] d;
    logic        we;
    logic        rs;
    logic        is_th;
    logic        bad_a;
    logic        running;
    int unsigned idx;
    a  = bus.DMEM_addr;
    d  = bus.DMEM_wr_data;
    we = bus.DMEM_wr_en;
    rs = bus.DMEM_rst;
    if (!Reset_n) begin
      m_rd = 0; m_mbox = 0; m_done = 0; m_pass = 0; m_num = 0; m_cnt = 0; m_err = 0;
      return;
    end
    is_th   = (a == TOHOST);
    idx     = int'(a >> 2);
    bad_a   = (a % 4 != 0) || (idx >= DEPTH && !is_th);
    running = !m_done;
    if (rs) m_rd = 0;
    else if (is_th) m_rd = m_mbox;
    else if (bad_a) m_rd = 0;
    else if (m_mem.exists(int'(idx))) m_rd = m_mem[int'(idx)];
    else m_rd = 'x;
    if (bad_a && (we || running)) m_err = 1;
    if (running && m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 1;
    if (we && !rs && !bad_a) begin
      if (is_th) begin
        m_mbox = d;
        if (running && d[0]) begin
          m_done = 1;
          m_pass = (d == 32'd1);
          m_num  = m_pass ? 31'd0 : d[31:1];
        end
      end else begin
        m_mem[int'(idx)] = d;
      end
    end
  endtask

  task automatic step();
    model_edge();
    @(posedge Clk);
    #1;
  endtask

  task automatic do_reset();
    Reset_n = 1'b0;
    drive(TOHOST, 32'd0, 1'b0, 1'b0);
    step();
    Reset_n = 1'b1;
  endtask

  task automatic test_reset();
    Reset_n = 1'b0;
    drive(TOHOST, 32'd0, 1'b0, 1'b0);
    step();
    step();
    total++; if (bus.DMEM_rd_data !== 32'd0) begin bad++;
      $display("FAIL reset_rd: got %h want 0", bus.DMEM_rd_data); end
    total++; if (Test_done !== 1'b0) begin bad++;
      $display("FAIL reset_done: got %b want 0", Test_done); end
    total++; if (Test_pass !== 1'b0) begin bad++;
      $display("FAIL reset_pass: got %b want 0", Test_pass); end
    total++; if (Test_num !== 31'd0) begin bad++;
      $display("FAIL reset_num: got %h want 0", Test_num); end
    total++; if (Cycle_count !== 32'd0) begin bad++;
      $display("FAIL reset_cnt: got %0d want 0", Cycle_count); end
    total++; if (Addr_err !== 1'b0) begin bad++;
      $display("FAIL reset_err: got %b want 0", Addr_err); end
    Reset_n = 1'b1;
  endtask

  task automatic preload();
    for (int i = 0; i < 64; i++) begin
      drive(32'(i * 4), $urandom, 1'b1, 1'b0);
      step();
    end
  endtask

  task automatic test_write_read();
    drive(32'h10, 32'hDEAD_BEEF, 1'b1, 1'b0);
    step();
    drive(32'h10, 32'h0, 1'b0, 1'b0);
    step();
    total++; if (bus.DMEM_rd_data !== 32'hDEAD_BEEF) begin bad++;
      $display("FAIL wr_rd: got %h want deadbeef", bus.DMEM_rd_data); end
    total++; if (Addr_err !== 1'b0) begin bad++;
      $display("FAIL wr_rd_err: got %b want 0", Addr_err); end
  endtask

  task automatic test_read_first();
    drive(32'h20, 32'h3, 1'b1, 1'b0);
    step();
    drive(32'h20, 32'h5, 1'b1, 1'b0);
    step();
    total++; if (bus.DMEM_rd_data !== 32'h3) begin bad++;
      $display("FAIL read_first_old: got %h want 3", bus.DMEM_rd_data); end
    drive(32'h20, 32'h0, 1'b0, 1'b0);
    step();
    total++; if (bus.DMEM_rd_data !== 32'h5) begin bad++;
      $display("FAIL read_first_new: got %h want 5", bus.DMEM_rd_data); end
  endtask

  task automatic test_addr_err();
    drive(32'h0, 32'h1111_0000, 1'b1, 1'b0);
    step();
    drive(32'h2, 32'h2222_2222, 1'b1, 1'b0);
    step();
    total++; if (Addr_err !== 1'b1) begin bad++;
      $display("FAIL misalign_err: got %b want 1", Addr_err); end
    drive(32'h0, 32'h0, 1'b0, 1'b0);
    step();
    total++; if (bus.DMEM_rd_data !== 32'h1111_0000) begin bad++;
      $display("FAIL misalign_nowrite: got %h want 11110000", bus.DMEM_rd_data); end
    drive(32'(DEPTH * 4), 32'h3333_3333, 1'b1, 1'b0);
    step();
    drive(32'(DEPTH * 4), 32'h0, 1'b0, 1'b0);
    step();
    total++; if (bus.DMEM_rd_data !== 32'h0) begin bad++;
      $display("FAIL oor_read: got %h want 0", bus.DMEM_rd_data); end
    do_reset();
  endtask

  task automatic test_dmem_rst();
    drive(32'h40, 32'hA5A5_0040, 1'b1, 1'b0);
    step();
    drive(32'h40, 32'h0, 1'b0, 1'b0);
    step();
    drive(32'h40, 32'hFFFF_0000, 1'b1, 1'b1);
    step();
    total++; if (bus.DMEM_rd_data !== 32'h0) begin bad++;
      $display("FAIL flush_rd: got %h want 0", bus.DMEM_rd_data); end
    drive(32'h40, 32'h0, 1'b0, 1'b0);
    step();
    total++; if (bus.DMEM_rd_data !== 32'hA5A5_0040) begin bad++;
      $display("FAIL flush_nowrite: got %h want a5a50040", bus.DMEM_rd_data); end
  endtask

  task automatic test_reset_blocks_write();
    drive(32'h44, 32'h4444_4444, 1'b1, 1'b0);
    step();
    Reset_n = 1'b0;
    drive(32'h44, 32'h0000_0BAD, 1'b1, 1'b0);
    step();
    Reset_n = 1'b1;
    drive(32'h44, 32'h0, 1'b0, 1'b0);
    step();
    total++; if (bus.DMEM_rd_data !== 32'h4444_4444) begin bad++;
      $display("FAIL reset_nowrite: got %h want 44444444", bus.DMEM_rd_data); end
  endtask

  task automatic test_pass();
    do_reset();
    for (int i = 0; i < 50; i++) begin
      drive(TOHOST, 32'h0, 1'b0, 1'b0);
      step();
    end
    drive(TOHOST, 32'h1, 1'b1, 1'b0);
    step();
    total++; if (Test_done !== 1'b1) begin bad++;
      $display("FAIL pass_done: got %b want 1", Test_done); end
    total++; if (Test_pass !== 1'b1) begin bad++;
      $display("FAIL pass_pass: got %b want 1", Test_pass); end
    total++; if (Test_num !== 31'd0) begin bad++;
      $display("FAIL pass_num: got %h want 0", Test_num); end
    total++; if (Cycle_count !== 32'd51) begin bad++;
      $display("FAIL pass_cnt: got %0d want 51", Cycle_count); end
    drive(TOHOST, 32'h7, 1'b1, 1'b0);
    step();
    for (int i = 0; i < 5; i++) begin
      drive(TOHOST, 32'h0, 1'b0, 1'b0);
      step();
    end
    total++; if (Test_done !== 1'b1 || Test_pass !== 1'b1 || Test_num !== 31'd0) begin bad++;
      $display("FAIL pass_sticky: got done=%b pass=%b num=%h want 1 1 0",
               Test_done, Test_pass, Test_num); end
    total++; if (Cycle_count !== 32'd51) begin bad++;
      $display("FAIL pass_freeze: got %0d want 51", Cycle_count); end
  endtask

  task automatic test_fail_and_reset();
    do_reset();
    drive(TOHOST, 32'h6, 1'b1, 1'b0);
    step();
    total++; if (Test_done !== 1'b0) begin bad++;
      $display("FAIL even_status_done: got %b want 0", Test_done); end
    drive(TOHOST, 32'h0, 1'b0, 1'b0);
    step();
    total++; if (bus.DMEM_rd_data !== 32'h6) begin bad++;
      $display("FAIL mailbox_read: got %h want 6", bus.DMEM_rd_data); end
    drive(TOHOST, 32'h7, 1'b1, 1'b0);
    step();
    total++; if (Test_done !== 1'b1 || Test_pass !== 1'b0) begin bad++;
      $display("FAIL fail_state: got done=%b pass=%b want 1 0", Test_done, Test_pass); end
    total++; if (Test_num !== 31'd3) begin bad++;
      $display("FAIL fail_num: got %0d want 3", Test_num); end
    do_reset();
    total++; if (Test_done !== 1'b0 || Test_pass !== 1'b0 || Test_num !== 31'd0 ||
                 Cycle_count !== 32'd0 || Addr_err !== 1'b0) begin bad++;
      $display("FAIL fail_reset: got done=%b pass=%b num=%h cnt=%0d err=%b want all 0",
               Test_done, Test_pass, Test_num, Cycle_count, Addr_err); end
    drive(32'h10, 32'h0, 1'b0, 1'b0);
    step();
    total++; if (bus.DMEM_rd_data !== 32'hDEAD_BEEF) begin bad++;
      $display("FAIL fail_reset_mem: got %h want deadbeef", bus.DMEM_rd_data); end
  endtask

  task automatic test_random();
    logic [31:0] a;
    logic [31:0] d;
    logic        we;
    logic        rs;
    int          sel;
    do_reset();
    for (int i = 0; i < 800; i++) begin
      Reset_n = ($urandom_range(0, 99) < 3) ? 1'b0 : 1'b1;
      sel = int'($urandom_range(0, 9));
      we  = 1'($urandom_range(0, 1));
      rs  = ($urandom_range(0, 19) == 0);
      d   = $urandom;
      if (sel <= 5) begin
        a = 32'($urandom_range(0, 63)) << 2;
      end else if (sel == 7) begin
        a = (32'($urandom_range(0, 63)) << 2) + 32'($urandom_range(1, 3));
      end else if (sel == 8) begin
        a = 32'($urandom_range(DEPTH, 4 * DEPTH)) << 2;
      end else begin
        a = TOHOST;
        case ($urandom_range(0, 5))
          0: d = 32'h0;
          1: d = 32'h1;
          2: d = 32'h2;
          3: d = 32'h7;
          default: d = $urandom;
        endcase
      end
      if (rs && (sel == 7 || sel == 8)) a = 32'h0;
      drive(a, d, we, rs);
      step();
      total++; if (bus.DMEM_rd_data !== m_rd) begin bad++;
        $display("FAIL rnd_rd[%0d]: got %h want %h", i, bus.DMEM_rd_data, m_rd); end
      total++; if (Test_done !== m_done) begin bad++;
        $display("FAIL rnd_done[%0d]: got %b want %b", i, Test_done, m_done); end
      total++; if (Test_pass !== m_pass) begin bad++;
        $display("FAIL rnd_pass[%0d]: got %b want %b", i, Test_pass, m_pass); end
      total++; if (Test_num !== m_num) begin bad++;
        $display("FAIL rnd_num[%0d]: got %h want %h", i, Test_num, m_num); end
      total++; if (Cycle_count !== m_cnt) begin bad++;
        $display("FAIL rnd_cnt[%0d]: got %0d want %0d", i, Cycle_count, m_cnt); end
      total++; if (Addr_err !== m_err) begin bad++;
        $display("FAIL rnd_err[%0d]: got %b want %b", i, Addr_err, m_err); end
    end
    Reset_n = 1'b1;
  endtask

  initial begin
    Reset_n = 1'b0;
    drive(TOHOST, 32'h0, 1'b0, 1'b0);
    test_reset();
    preload();
    test_write_read();
    test_read_first();
    test_addr_err();
    test_dmem_rst();
    test_reset_blocks_write();
    test_pass();
    test_fail_and_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
